if_fetch_unit: RTL

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It presents each fetched instruction and its PC+4 on `nPC_if`/`IR_if`, which feed the IF/ID pipeline register. It absorbs variable memory latency, decode-side stalls through a one-entry skid register, and taken-branch/jump redirects, squashing any in-flight fetch.

---
 rtl/if_fetch_unit_pkg.sv | 22 ++
 rtl/fetch_skid_reg.sv | 55 +++++
 rtl/if_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encodings stay as plain constants so they match the legacy definitions header.
package if_fetch_unit_pkg;

  localparam int unsigned WORD = 32;

  typedef logic [WORD-1:0] word_t;
  typedef logic [1:0]      fetch_state_t;

  localparam word_t ZERO    = '0;
  localparam word_t PC_STEP = word_t'(4);

  localparam fetch_state_t FETCH_IDLE = 2'd0;
  localparam fetch_state_t FETCH_REQ  = 2'd1;
  localparam fetch_state_t FETCH_DROP = 2'd2;
  localparam fetch_state_t FETCH_SKID = 2'd3;

  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for an instruction fetched while decode is stalled.
// Priority: clear, then load, then drain.
module fetch_skid_reg
  import if_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  word_t ir_in,
  input  word_t npc_in,
  output logic  valid,
  output word_t ir,
  output word_t npc
);

  logic  valid_q, valid_d;
  word_t ir_q, ir_d;
  word_t npc_q, npc_d;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    if (clear) begin
      valid_d = 1'b0;
      ir_d    = ZERO;
      npc_d   = ZERO;
    end else if (load) begin
      valid_d = 1'b1;
      ir_d    = ir_in;
      npc_d   = npc_in;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ir_q    <= ZERO;
      npc_q   <= ZERO;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
    end
  end

  assign valid = valid_q;
  assign ir    = ir_q;
  assign npc   = npc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, skid for decode stalls, redirects.
// Optional build macro FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC = ZERO,
  parameter int unsigned DELAY    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_rdata,
  output logic [WORD-1:0] nPC_if,
  output logic [WORD-1:0] IR_if,
  output logic            valid_if,
  output logic            misalign
);

  // DELAY only shaped simulation timing in the legacy model; registers here update at the edge.
  if (DELAY != 0) begin : g_sim_delay
  end

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        drop_addr_q, drop_addr_d;
  word_t        ir_q, ir_d;
  word_t        npc_q, npc_d;
  logic         valid_q, valid_d;

  logic  skid_load, skid_drain, skid_clear;
  logic  skid_valid;
  word_t skid_ir, skid_npc;
  word_t pc_inc;
  logic  slot_blocked, slot_consume;

  assign pc_inc       = pc_q + PC_STEP;
  assign slot_blocked = valid_q & stall;
  assign slot_consume = valid_q & ~stall;

  fetch_skid_reg u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .drain  (skid_drain),
    .clear  (skid_clear),
    .ir_in  (imem_rdata),
    .npc_in (pc_inc),
    .valid  (skid_valid),
    .ir     (skid_ir),
    .npc    (skid_npc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    ir_d        = ir_q;
    npc_d       = npc_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;

    if (slot_consume) begin
      valid_d = 1'b0;
      ir_d    = ZERO;
    end

    case (state_q)
      FETCH_IDLE: begin
        if (!slot_blocked) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_ack) begin
          pc_d = pc_inc;
          if (slot_blocked) begin
            skid_load = 1'b1;
            state_d   = FETCH_SKID;
          end else begin
            ir_d    = imem_rdata;
            npc_d   = pc_inc;
            valid_d = 1'b1;
          end
        end
      end
      FETCH_SKID: begin
        if (!stall && skid_valid) begin
          ir_d       = skid_ir;
          npc_d      = skid_npc;
          valid_d    = 1'b1;
          skid_drain = 1'b1;
          state_d    = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (imem_ack) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect overrides everything above; nPC_if keeps its last value while the slot is empty.
    if (redirect) begin
      pc_d       = align_word(redirect_pc);
      valid_d    = 1'b0;
      ir_d       = ZERO;
      npc_d      = npc_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b1;
      case (state_q)
        FETCH_REQ: begin
          if (imem_ack) begin
            state_d = FETCH_REQ;
          end else begin
            state_d     = FETCH_DROP;
            drop_addr_d = pc_q;
          end
        end
        FETCH_IDLE, FETCH_SKID: state_d = FETCH_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      ir_q        <= ZERO;
      npc_q       <= ZERO;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req  = (state_q == FETCH_REQ) || (state_q == FETCH_DROP);
  assign imem_addr = (state_q == FETCH_DROP) ? drop_addr_q : pc_q;
  assign nPC_if    = npc_q;
  assign IR_if     = ir_q;
  assign valid_if  = valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q | (redirect & (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule
